freq_gate_ctrl: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 28 ++
 rtl/fxin_edge_sync.sv | 29 ++
 rtl/freq_gate_ctrl.sv | 154 +++++++++++++++
 tb/tb_freq_gate_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter clk-domain blocks:
// FSM state encoding, gate-range codes, count width and gate-length helper.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [1:0] RANGE_10MS  = 2'd0;
    localparam logic [1:0] RANGE_100MS = 2'd1;
    localparam logic [1:0] RANGE_1S    = 2'd2;

    localparam int unsigned CNT_W = 14;

    // Gate length in clk cycles for a range: 1 s / 10^(2 - range)
    function automatic int unsigned gate_len(input int unsigned cycles_1s,
                                             input logic [1:0]  rng);
        case (rng)
            RANGE_10MS:  gate_len = cycles_1s / 100;
            RANGE_100MS: gate_len = cycles_1s / 10;
            default:     gate_len = cycles_1s;
        endcase
    endfunction

endpackage

// File: rtl/fxin_edge_sync.sv
// Fxin synchroniser (two flops) plus a third flop for rising-edge detect.
// edge_pulse is a single clk-cycle pulse per Fxin rising edge.
module fxin_edge_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Fxin,
    output logic edge_pulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchroniser chain and delayed copy for edge detection
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= Fxin;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

endmodule

// File: rtl/freq_gate_ctrl.sv
// Frequency-counter gate controller: sequenced gate window, Fxin edge count
// with saturation, Start/Busy/Valid handshake.
// Optional auto-ranging of the gate time is enabled by defining
// FREQ_AUTORANGE_EN; otherwise the range comes from Range_Sel.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES_1S = 100_000_000,
    parameter int unsigned CNT_MAX        = 9999,
    parameter int unsigned UNDER_THRESH   = 1000,
    parameter int unsigned TMR_W          = 27
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Fxin,
    input  logic             Start,
    input  logic             Abort,
    input  logic [1:0]       Range_Sel,
    output logic             Busy,
    output logic             Valid,
    output logic [CNT_W-1:0] Count_Out,
    output logic [1:0]       Res_Range,
    output logic             Overflow
);

    localparam logic [TMR_W-1:0] TMR_LD_10MS  = TMR_W'(gate_len(GATE_CYCLES_1S, RANGE_10MS) - 1);
    localparam logic [TMR_W-1:0] TMR_LD_100MS = TMR_W'(gate_len(GATE_CYCLES_1S, RANGE_100MS) - 1);
    localparam logic [TMR_W-1:0] TMR_LD_1S    = TMR_W'(gate_len(GATE_CYCLES_1S, RANGE_1S) - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_UNDER    = CNT_W'(UNDER_THRESH);

    state_t           state;
    state_t           state_nxt;
    logic             edge_pulse;
    logic [CNT_W-1:0] counter;
    logic [TMR_W-1:0] timer;
    logic [1:0]       range;
    logic             ovf_flag;

    logic             cnt_full;
    logic             ovf_evt;
    logic             restart;
    logic             gate_done;
    logic [1:0]       arm_range;
    logic [TMR_W-1:0] tmr_load;
    logic [CNT_W-1:0] cnt_nxt;
    logic             flag_nxt;

    fxin_edge_sync u_sync (
        .Clk        (Clk),
        .Rst        (Rst),
        .Fxin       (Fxin),
        .edge_pulse (edge_pulse)
    );

    // Datapath decode: overflow/restart detection, range to arm with, next count
    always_comb begin
        cnt_full  = (counter == CNT_SAT);
        ovf_evt   = (state == GATE) && edge_pulse && cnt_full;
        gate_done = (state == GATE) && (timer == '0);
`ifdef FREQ_AUTORANGE_EN
        restart   = ovf_evt && (range != RANGE_10MS);
        arm_range = range;
`else
        restart   = 1'b0;
        arm_range = (Range_Sel == 2'd3) ? RANGE_1S : Range_Sel;
`endif
        case (arm_range)
            RANGE_10MS:  tmr_load = TMR_LD_10MS;
            RANGE_100MS: tmr_load = TMR_LD_100MS;
            default:     tmr_load = TMR_LD_1S;
        endcase
        cnt_nxt  = (edge_pulse && !cnt_full) ? counter + 1'b1 : counter;
        flag_nxt = ovf_flag | ovf_evt;
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; Abort has priority over restart and gate completion
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = ARM;
            ARM:     state_nxt = Abort ? IDLE : GATE;
            GATE: begin
                if (Abort)          state_nxt = IDLE;
                else if (restart)   state_nxt = ARM;
                else if (gate_done) state_nxt = LATCH;
            end
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        Busy  = (state == ARM) || (state == GATE);
        Valid = (state == LATCH);
    end

    // Counter, timer, range and result registers.
    // Results are loaded on the last GATE cycle (including that cycle's edge)
    // so they are already stable while Valid is high in LATCH.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            counter   <= '0;
            timer     <= '0;
            range     <= RANGE_1S;
            ovf_flag  <= 1'b0;
            Count_Out <= '0;
            Res_Range <= RANGE_1S;
            Overflow  <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (!Abort) begin
                        counter  <= '0;
                        ovf_flag <= 1'b0;
                        timer    <= tmr_load;
                        range    <= arm_range;
                    end
                end
                GATE: begin
                    if (!Abort) begin
                        if (restart) begin
                            range <= range - 1'b1;
                        end else begin
                            counter  <= cnt_nxt;
                            ovf_flag <= flag_nxt;
                            if (timer != '0) timer <= timer - 1'b1;
                            if (gate_done) begin
                                Count_Out <= cnt_nxt;
                                Res_Range <= range;
                                Overflow  <= flag_nxt;
                            end
                        end
                    end
                end
                LATCH: begin
`ifdef FREQ_AUTORANGE_EN
                    if ((counter < CNT_UNDER) && !ovf_flag && (range < RANGE_1S))
                        range <= range + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Scoreboard bench for freq_gate_ctrl (GATE_CYCLES_1S=10000, CNT_MAX=99,
// UNDER_THRESH=10). Stimulus pushes expected results; a monitor pops and
// compares on each Valid. Covers both FREQ_AUTORANGE_EN builds.
`timescale 1ns/1ps
module tb_freq_gate_ctrl;
    import freq_meter_pkg::*;

    localparam int unsigned G1S  = 10000;
    localparam int unsigned CMAX = 99;
    localparam int unsigned UTH  = 10;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Fxin = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic [1:0]  Range_Sel = 2'd2;
    logic        Busy;
    logic        Valid;
    logic [13:0] Count_Out;
    logic [1:0]  Res_Range;
    logic        Overflow;

    freq_gate_ctrl #(
        .GATE_CYCLES_1S (G1S),
        .CNT_MAX        (CMAX),
        .UNDER_THRESH   (UTH),
        .TMR_W          (14)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Fxin      (Fxin),
        .Start     (Start),
        .Abort     (Abort),
        .Range_Sel (Range_Sel),
        .Busy      (Busy),
        .Valid     (Valid),
        .Count_Out (Count_Out),
        .Res_Range (Res_Range),
        .Overflow  (Overflow)
    );

    typedef struct {
        string       name;
        int unsigned cnt_lo;
        int unsigned cnt_hi;
        int unsigned rng;
        int unsigned ovf;
        int unsigned t_lo;
        int unsigned t_hi;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned fx_per = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Fxin source: square wave with period fx_per clk cycles (0 = held low)
    initial begin
        forever begin
            if (fx_per == 0) begin
                Fxin = 1'b0;
                @(negedge Clk);
            end else begin
                Fxin = 1'b1;
                repeat (fx_per / 2) @(negedge Clk);
                Fxin = 1'b0;
                repeat (fx_per - fx_per / 2) @(negedge Clk);
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int unsigned act,
                           input int unsigned lo, input int unsigned hi);
        checks++;
        if (act >= lo && act <= hi) passes++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Monitor: every Valid must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Rst && Valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk_rng({e.name, "_count"}, Count_Out, e.cnt_lo, e.cnt_hi);
                    chk({e.name, "_range"}, Res_Range, e.rng);
                    chk({e.name, "_ovf"}, Overflow, e.ovf);
                    chk_rng({e.name, "_valid_cycle"}, cyc, e.t_lo, e.t_hi);
                    chk({e.name, "_busy_in_latch"}, Busy, 0);
                end
            end
        end
    end

    // Pulse Start for one cycle; t is the cycle in which Start is sampled
    task automatic do_start(output int unsigned t);
        @(negedge Clk);
        Start = 1'b1;
        t = cyc;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic push_exp(input string name, input int unsigned lo, input int unsigned hi,
                            input int unsigned rng, input int unsigned ovf,
                            input int unsigned tlo, input int unsigned thi);
        exp_t e;
        e.name = name; e.cnt_lo = lo; e.cnt_hi = hi; e.rng = rng; e.ovf = ovf;
        e.t_lo = tlo; e.t_hi = thi;
        sb.push_back(e);
    endtask

    // Bounded wait for the scoreboard to empty, then a few quiet cycles
    task automatic drain(input string name, input int unsigned budget);
        for (int unsigned i = 0; i < budget && sb.size() != 0; i++) @(negedge Clk);
        chk({name, "_drained"}, sb.size(), 0);
        repeat (5) @(negedge Clk);
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, "_busy"}, Busy, 0);
        chk({name, "_valid"}, Valid, 0);
        chk({name, "_count"}, Count_Out, 0);
        chk({name, "_ovf"}, Overflow, 0);
        chk({name, "_res_range"}, Res_Range, 2);
    endtask

    // Abort at gate cycle 50, then confirm idle and results untouched
    task automatic abort_test(input int unsigned cnt, input int unsigned rng, input int unsigned ovf);
        int unsigned t;
        do_start(t);
        repeat (50) @(negedge Clk);
        chk("abort_busy_before", Busy, 1);
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        chk("abort_busy_after", Busy, 0);
        chk("abort_valid_after", Valid, 0);
        repeat (1200) @(negedge Clk);
        chk("abort_count_kept", Count_Out, cnt);
        chk("abort_range_kept", Res_Range, rng);
        chk("abort_ovf_kept", Overflow, ovf);
    endtask

    // Reset held 3 cycles in the middle of a gate
    task automatic reset_test();
        int unsigned t;
        do_start(t);
        repeat (100) @(negedge Clk);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk_reset_vals("midrst_held");
        Rst = 1'b0;
        @(negedge Clk);
        chk_reset_vals("midrst_after");
        repeat (1200) @(negedge Clk);
        chk("midrst_no_restart", Busy, 0);
    endtask

    initial begin
        int unsigned t;
        repeat (3) @(negedge Clk);
        chk_reset_vals("reset");
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

`ifdef FREQ_AUTORANGE_EN
        // Cascade: range 2 and 1 overflow (100th edge ~400 gate cycles each), range 0 counts 25
        fx_per = 4;
        repeat (8) @(negedge Clk);
        do_start(t);
        push_exp("cascade", 25, 25, 0, 0, t + 896, t + 906);
        drain("cascade", 1200);

        // Low frequency in range 0: at most one edge, then range steps up to 1
        fx_per = 400;
        repeat (10) @(negedge Clk);
        do_start(t);
        push_exp("uprange0", 0, 1, 0, 0, t + 102, t + 102);
        drain("uprange0", 300);

        do_start(t);
        push_exp("uprange1", 2, 3, 1, 0, t + 1002, t + 1002);
        drain("uprange1", 1300);

        // Range now 2: 10000-cycle gate, 25 edges; extra Start mid-gate is ignored
        do_start(t);
        push_exp("busy_start", 25, 25, 2, 0, t + 10002, t + 10002);
        repeat (300) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("busy_start_busy", Busy, 1);
        drain("busy_start", 10300);

        // Abort before the first overflow; range stays 2
        fx_per = 4;
        repeat (8) @(negedge Clk);
        abort_test(25, 2, 0);

        reset_test();

        // Range is 2 after reset: full 1 s gate
        fx_per = 400;
        repeat (10) @(negedge Clk);
        do_start(t);
        push_exp("post_reset", 25, 25, 2, 0, t + 10002, t + 10002);
        drain("post_reset", 10300);
`else
        // Fixed range 0, period 4: 100-cycle gate, 25 edges
        fx_per = 4;
        Range_Sel = 2'd0;
        repeat (8) @(negedge Clk);
        do_start(t);
        push_exp("fix_r0", 25, 25, 0, 0, t + 102, t + 102);
        drain("fix_r0", 300);

        // Fixed range 1: 250 edges saturate at 99; Start mid-gate ignored
        Range_Sel = 2'd1;
        do_start(t);
        push_exp("fix_r1_sat", 99, 99, 1, 1, t + 1002, t + 1002);
        repeat (200) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        chk("busy_start_busy", Busy, 1);
        drain("fix_r1_sat", 1300);

        // Abort in range 0 leaves the previous result in place
        Range_Sel = 2'd0;
        abort_test(99, 1, 1);

        // Fixed range 2, period 4: saturates over the full gate
        Range_Sel = 2'd2;
        do_start(t);
        push_exp("fix_r2_sat", 99, 99, 2, 1, t + 10002, t + 10002);
        drain("fix_r2_sat", 10300);

        // Range_Sel 3 behaves as range 2; period 400 gives 25 edges, no overflow
        fx_per = 400;
        Range_Sel = 2'd3;
        repeat (10) @(negedge Clk);
        do_start(t);
        push_exp("fix_sel3", 25, 25, 2, 0, t + 10002, t + 10002);
        drain("fix_sel3", 10300);

        // Range 0 with period 400: at most one edge
        Range_Sel = 2'd0;
        do_start(t);
        push_exp("fix_r0_slow", 0, 1, 0, 0, t + 102, t + 102);
        drain("fix_r0_slow", 300);

        Range_Sel = 2'd1;
        reset_test();
`endif

        chk("final_queue_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
